// File: rtl/mon_pkg.sv
// Shared types and constants for the end-of-test store monitor.
package mon_pkg;

    // Verdict FSM states; RUN is the only non-terminal state.
    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } mon_state_e;

    // Width of the store and cycle counters.
    localparam int unsigned CNT_W = 16;

    // One logged store: address in the upper word, data in the lower word.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    localparam int unsigned LOG_ENTRY_W = $bits(log_entry_t);

endpackage

// File: rtl/store_log_fifo.sv
// Store log: FWFT FIFO that drops its oldest entry when pushed while full.
module store_log_fifo
    import mon_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = LOG_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_entry,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_entry,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign rd_entry = empty ? '0 : mem_q[head_q];

    // Pointer and occupancy update; a push into a full log advances the head
    // unless a real pop is already doing so.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        overflow = push && full && !do_pop;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (do_pop || overflow) begin
            head_d = head_q + 1'b1;
        end
        if (push && !do_pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are masked by empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

endmodule

// File: rtl/mem_write_monitor.sv
// End-of-test monitor: watches the data-memory store bus, logs stores and
// latches a sticky PASS / FAIL / TIMEOUT verdict.
module mem_write_monitor
    import mon_pkg::*;
#(
    parameter logic [31:0]      PASS_ADDR      = 32'd84,
    parameter logic [31:0]      PASS_DATA      = 32'd7,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd100,
    parameter int unsigned      LOG_DEPTH      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       dataadr,
    input  logic [31:0]       writedata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  store_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              log_overflow,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [31:0]       rd_addr,
    output logic [31:0]       rd_data
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = TIMEOUT_CYCLES - 16'd1;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             log_overflow_q, log_overflow_d;
    logic             accept;
    logic             fifo_overflow;
    logic             fifo_empty;
    logic             fifo_full;
    log_entry_t       wr_entry;
    log_entry_t       head_entry;

    assign accept        = (state_q == ST_RUN) && memwrite;
    assign wr_entry.addr = dataadr;
    assign wr_entry.data = writedata;

    store_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_ENTRY_W)
    ) u_log (
        .clk      (clk),
        .rst      (reset),
        .push     (accept),
        .wr_entry (wr_entry),
        .pop      (rd_en),
        .rd_entry (head_entry),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (fifo_overflow)
    );

    // Verdict decision and counter updates; a signature store beats timeout.
    always_comb begin
        state_d        = state_q;
        store_count_d  = store_count_q;
        cycle_count_d  = cycle_count_q;
        log_overflow_d = log_overflow_q | fifo_overflow;
        if (state_q == ST_RUN) begin
            if (accept && dataadr == PASS_ADDR) begin
                state_d = (writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
            end else if (cycle_count_q == LAST_CYCLE) begin
                state_d = ST_TIMEOUT;
            end
            if (cycle_count_q != LAST_CYCLE) begin
                cycle_count_d = cycle_count_q + 1'b1;
            end
        end
        if (accept && store_count_q != '1) begin
            store_count_d = store_count_q + 1'b1;
        end
    end

    // State, counters and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RUN;
            store_count_q  <= '0;
            cycle_count_q  <= '0;
            log_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            store_count_q  <= store_count_d;
            cycle_count_q  <= cycle_count_d;
            log_overflow_q <= log_overflow_d;
        end
    end

    assign done         = (state_q != ST_RUN);
    assign pass         = (state_q == ST_PASS);
    assign fail         = (state_q == ST_FAIL);
    assign timeout      = (state_q == ST_TIMEOUT);
    assign store_count  = store_count_q;
    assign cycle_count  = cycle_count_q;
    assign log_overflow = log_overflow_q;
    assign rd_valid     = !fifo_empty;
    assign rd_addr      = head_entry.addr;
    assign rd_data      = head_entry.data;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed self-checking bench for mem_write_monitor with a store-log scoreboard.
module tb_mem_write_monitor;

    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] store_count;
    logic [15:0] cycle_count;
    logic        log_overflow;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;

    int unsigned total;
    int unsigned bad;
    logic [63:0] sb [$];

    mem_write_monitor #(
        .PASS_ADDR      (32'd84),
        .PASS_DATA      (32'd7),
        .TIMEOUT_CYCLES (16'd100),
        .LOG_DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .store_count  (store_count),
        .cycle_count  (cycle_count),
        .log_overflow (log_overflow),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [3:0] exp_dpft);
        check(tag, {60'd0, done, pass, fail, timeout}, {60'd0, exp_dpft});
    endtask

    // Reset for three cycles, released at a falling edge.
    task automatic do_reset();
        reset    = 1'b1;
        memwrite = 1'b0;
        rd_en    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    // Drive one store for one rising edge; the model logs it only if accepted.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit accepted);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        if (accepted) begin
            sb.push_back({a, d});
            if (sb.size() > DEPTH) void'(sb.pop_front());
        end
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    // Compare the log head against the scoreboard and pop it.
    task automatic pop_check(input string tag);
        logic [63:0] exp;
        check({tag, "_valid"}, {63'd0, rd_valid}, 64'd1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty_model expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            check({tag, "_entry"}, {rd_addr, rd_data}, exp);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        rd_en     = 1'b0;

        // Reset values
        @(negedge clk);
        check_status("rst_status", 4'b0000);
        check("rst_counts", {32'd0, store_count, cycle_count}, 64'd0);
        check("rst_log", {62'd0, log_overflow, rd_valid}, 64'd0);
        check("rst_rd", {rd_addr, rd_data}, 64'd0);

        // Signature pass
        do_reset();
        do_store(32'h50, 32'h7, 1'b1);
        check_status("pass_pre", 4'b0000);
        do_store(32'h54, 32'h7, 1'b1);
        check_status("pass_status", 4'b1100);
        check("pass_count", {48'd0, store_count}, 64'd2);
        pop_check("pass_pop0");
        pop_check("pass_pop1");
        check("pass_drained", {63'd0, rd_valid}, 64'd0);

        // Wrong signature -> fail, later stores ignored
        do_reset();
        do_store(32'h54, 32'h6, 1'b1);
        check_status("fail_status", 4'b1010);
        do_store(32'h54, 32'h7, 1'b0);
        check_status("fail_sticky", 4'b1010);
        check("fail_count", {48'd0, store_count}, 64'd1);
        pop_check("fail_pop");
        check("fail_drained", {63'd0, rd_valid}, 64'd0);

        // Timeout after 100 idle cycles
        do_reset();
        repeat (99) @(negedge clk);
        check_status("to_pre", 4'b0000);
        check("to_pre_cyc", {48'd0, cycle_count}, 64'd99);
        @(negedge clk);
        check_status("to_status", 4'b1001);
        check("to_cyc", {48'd0, cycle_count}, 64'd99);
        repeat (5) @(negedge clk);
        check("to_frozen", {48'd0, cycle_count}, 64'd99);

        // Signature on the last allowed cycle beats timeout
        do_reset();
        repeat (99) @(negedge clk);
        do_store(32'd84, 32'd7, 1'b1);
        check_status("edge_status", 4'b1100);
        check("edge_cyc", {48'd0, cycle_count}, 64'd99);
        check("edge_count", {48'd0, store_count}, 64'd1);

        // Overflow: 10 stores into an 8-deep log
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_store(32'(i * 4), 32'(i), 1'b1);
        end
        check("ovf_flag", {63'd0, log_overflow}, 64'd1);
        check("ovf_count", {48'd0, store_count}, 64'd10);
        check("ovf_head", {rd_addr, rd_data}, {32'h8, 32'h2});
        for (int i = 0; i < 8; i++) begin
            pop_check($sformatf("ovf_pop%0d", i));
        end
        check("ovf_empty", {63'd0, rd_valid}, 64'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("ovf_pop_empty", {63'd0, rd_valid}, 64'd0);

        // Full log with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_store(32'(32'h100 + i * 4), 32'(i + 16), 1'b1);
        end
        check("pp_noovf_full", {63'd0, log_overflow}, 64'd0);
        check("pp_head", {rd_addr, rd_data}, sb[0]);
        void'(sb.pop_front());
        rd_en = 1'b1;
        do_store(32'h200, 32'h99, 1'b1);
        rd_en = 1'b0;
        check("pp_noovf", {63'd0, log_overflow}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            pop_check($sformatf("pp_pop%0d", i));
        end
        check("pp_empty", {63'd0, rd_valid}, 64'd0);

        // Asynchronous reset mid-run
        do_reset();
        do_store(32'h10, 32'h1, 1'b1);
        do_store(32'h14, 32'h2, 1'b1);
        do_store(32'h18, 32'h3, 1'b1);
        check("ar_pre_count", {48'd0, store_count}, 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check_status("ar_status", 4'b0000);
        check("ar_counts", {32'd0, store_count, cycle_count}, 64'd0);
        check("ar_log", {62'd0, log_overflow, rd_valid}, 64'd0);
        check("ar_rd", {rd_addr, rd_data}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        do_store(32'h20, 32'h5, 1'b1);
        check("ar_post_count", {48'd0, store_count}, 64'd1);
        pop_check("ar_pop");
        check("ar_empty", {63'd0, rd_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable end-of-test monitor that sits directly downstream of the processor `top` and consumes its data-memory store bus (`memwrite`, `dataadr`, `writedata`). It logs every store into a small FIFO, counts stores and cycles, and produces a sticky verdict:

- PASS when the test program writes the agreed signature word to the agreed address.
- FAIL when any other value is written to that address.
- TIMEOUT when no verdict arrives within a cycle budget.

Benches and on-board debug read the verdict and drain the store log instead of inspecting waveforms.

## Interface
Parameters:
- `PASS_ADDR`, 32'd84 — signature address.
- `PASS_DATA`, 32'd7 — signature value.
- `TIMEOUT_CYCLES`, 16'd100 — cycles allowed in RUN before TIMEOUT; must be ≥ 1.
- `LOG_DEPTH`, 8 — store-log entries; power of two, ≥ 2.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `memwrite` in 1 — store strobe from `top`.
- `dataadr` in 32 — store address.
- `writedata` in 32 — store data.
- `done` out 1 — verdict reached (state ≠ RUN).
- `pass` out 1 — state = PASS.
- `fail` out 1 — state = FAIL.
- `timeout` out 1 — state = TIMEOUT.
- `store_count` out 16 — accepted stores, saturating at 16'hFFFF.
- `cycle_count` out 16 — cycles spent in RUN.
- `log_overflow` out 1 — sticky; a log entry was overwritten.
- `rd_en` in 1 — pop the log head.
- `rd_valid` out 1 — log not empty.
- `rd_addr` out 32 — head entry address (first-word fall-through).
- `rd_data` out 32 — head entry data.

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN.
- PASS, FAIL and TIMEOUT are terminal until reset.
- In RUN, a store is accepted when `memwrite`=1 at a rising edge. Each accepted store:
  - pushes {`dataadr`, `writedata`} into the log;
  - increments `store_count` (saturating).
- Accepted store to `PASS_ADDR`:
  - `writedata` = `PASS_DATA` → PASS;
  - any other value → FAIL.
  - The signature store itself is logged and counted.
- No verdict store and `cycle_count` = `TIMEOUT_CYCLES`−1 → TIMEOUT.
- Same cycle as a signature store, the store wins over TIMEOUT.
- `cycle_count` increments every RUN cycle and freezes on leaving RUN.
- In terminal states `memwrite` is ignored: no push, no count change.
- Log read side works in every state, including after the verdict.
- Log push when full, no pop:
  - oldest entry is dropped (head advances) and the new entry is written;
  - occupancy stays at `LOG_DEPTH`;
  - `log_overflow` is set.
- Push and pop in the same cycle: both occur and occupancy is unchanged, including when full (no overflow in that case).
- Pop when empty: ignored.
- `rd_addr`/`rd_data` are don't-care when `rd_valid`=0.

## Timing
- Reset values of all outputs: `done`, `pass`, `fail`, `timeout`, `log_overflow`, `rd_valid` = 0; `store_count`, `cycle_count` = 0; `rd_addr`, `rd_data` = 0.
- Reset asserted mid-run: state returns to RUN, the log empties, and all counters and sticky bits clear immediately (asynchronous).
- Verdict latency: a store sampled at edge N drives `done` and its verdict bit high after edge N. Outputs are registered, so they are visible in the cycle following the store cycle.
- Log latency: a push at edge N makes `rd_valid`=1 after edge N.
- Pop timing: `rd_en` sampled at edge N advances the head after edge N.
- Status outputs are one-hot across `pass`/`fail`/`timeout` and never glitch (registered).
- `store_count` and `cycle_count` are 16-bit unsigned. `cycle_count` cannot exceed `TIMEOUT_CYCLES`−1.

## Structure
- Package `mon_pkg`:
  - state enum (RUN, PASS, FAIL, TIMEOUT);
  - a 16-bit counter width constant;
  - a log entry struct {addr[31:0], data[31:0]}.
- Sub-module `store_log_fifo`:
  - parameterized depth and entry width;
  - overwrite-on-full policy and FWFT read;
  - exposes `full`, `empty` and an overflow pulse.
- Top-level `mem_write_monitor`: verdict FSM, counters, sticky flags.

## Test plan
- Reset 3 cycles, then stores (0x50, 0x7) and (0x54, 0x7) with defaults → `done`=`pass`=1 one cycle after the second store; `store_count`=2; log pops (0x50, 7) then (0x54, 7).
- Store (0x54, 0x6) → `fail`=1 and `pass`=0. A later store (0x54, 0x7) → no change, and `store_count` stays 1.
- No stores for 100 cycles → `timeout`=1 and `cycle_count`=99 frozen. A signature store landing exactly on cycle 99 → `pass`=1 and `timeout`=0.
- 10 stores to 0x0…0x24 (data = index) with `LOG_DEPTH`=8 → `log_overflow`=1; first pop returns (0x8, 2); 8 pops empty the log; 9th pop ignored with `rd_valid`=0.
- Full log with simultaneous push and pop → occupancy stays 8 and `log_overflow` stays 0 (fresh reset).
- Assert `reset` asynchronously mid-run after 3 stores → all outputs 0 immediately; the next store after release gives `store_count`=1.
